// File: rtl/byte_queue.sv
`default_nettype none
// ============================================================================
//  Module   : byte_queue
//  Purpose  : Synchronous FIFO byte queue. Writes enter at the tail, reads
//             leave at the head. Push and pop strobes are independent, so
//             both ends can operate in the same cycle. Read data is
//             registered (1-clock latency) and flagged with dvalid.
//
//  Ports    : clk        rising-edge clock
//             rst        asynchronous active-high reset
//             push       write strobe, datain captured when accepted
//             datain     write data [DATA_W]
//             pop        read strobe
//             dataout    registered read data [DATA_W]
//             dvalid     one-cycle pulse, dataout updated by an accepted pop
//             full       count == DEPTH
//             empty      count == 0
//             count      entries held, 0..DEPTH [ADDR_W+1]
//             overflow   one-cycle pulse, push rejected
//             underflow  one-cycle pulse, pop rejected
//             almost_full / almost_empty  (only with QUEUE_ALMOST_FLAGS_EN)
//
//  Options  : `define QUEUE_ALMOST_FLAGS_EN adds parameter ALMOST_LVL and the
//             registered almost_full (count >= DEPTH-ALMOST_LVL) and
//             almost_empty (count <= ALMOST_LVL) outputs.
//
//  Revision : 1.0  initial release
// ============================================================================
module byte_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
`ifdef QUEUE_ALMOST_FLAGS_EN
    ,
    parameter int ALMOST_LVL = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] datain,
    input  logic              pop,
    output logic [DATA_W-1:0] dataout,
    output logic              dvalid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
`ifdef QUEUE_ALMOST_FLAGS_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   C_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE   = ADDR_W'(1);

    // Storage is deliberately not reset.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              dvalid_q;
    logic              full_q, empty_q;
    logic              overflow_q, underflow_q;

    logic w_pop_acc;
    logic w_push_acc;

    // A pop is only ever refused when empty. A push into a full queue is
    // allowed when the same-cycle pop frees the head slot; in that case
    // wr_ptr == rd_ptr and the read below sees the old entry because the
    // memory write only lands at the clock edge.
    assign w_pop_acc  = pop && !empty_q;
    assign w_push_acc = push && (!full_q || w_pop_acc);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dataout_d = dataout_q;

        if (w_push_acc) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop_acc) begin
            rd_ptr_d  = rd_ptr_q + C_PTR_ONE;
            dataout_d = mem[rd_ptr_q];
        end

        if (w_push_acc && !w_pop_acc) begin
            count_d = count_q + C_CNT_ONE;
        end else if (!w_push_acc && w_pop_acc) begin
            count_d = count_q - C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            mem[wr_ptr_q] <= datain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dataout_q   <= '0;
            dvalid_q    <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dataout_q   <= dataout_d;
            dvalid_q    <= w_pop_acc;
            // Flags come from the next count so they line up with count_q.
            full_q      <= (count_d == C_DEPTH_CNT);
            empty_q     <= (count_d == '0);
            overflow_q  <= push && !w_push_acc;
            underflow_q <= pop && !w_pop_acc;
        end
    end

`ifdef QUEUE_ALMOST_FLAGS_EN
    localparam logic [ADDR_W:0] C_AF_LVL = (ADDR_W + 1)'(DEPTH - ALMOST_LVL);
    localparam logic [ADDR_W:0] C_AE_LVL = (ADDR_W + 1)'(ALMOST_LVL);

    logic almost_full_q, almost_empty_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= (count_d >= C_AF_LVL);
            almost_empty_q <= (count_d <= C_AE_LVL);
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

    assign dataout   = dataout_q;
    assign dvalid    = dvalid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
`default_nettype wire
